// File: rtl/bit_serial_pkg.sv
// Shared types and constants for the bit-serial adder.
package bit_serial_pkg;

  localparam int unsigned BS_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } bs_state_e;

endpackage

// File: rtl/full_adder_dataflow.sv
// Single-bit full adder used as the arithmetic cell of the bit-serial adder.
module full_adder_dataflow (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell plus a registered carry.
// Optional subtract mode is enabled by defining BIT_SERIAL_SUB_EN.
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int unsigned WIDTH = BS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef BIT_SERIAL_SUB_EN
  input  logic             sub_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  bs_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, s_sr_q, sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, cout_q;
  logic             fa_sum, fa_cout;
  logic             last_bit;
  logic             final_cout;

  full_adder_dataflow u_fa (
    .A    (a_sr_q[0]),
    .B    (b_sr_q[0]),
    .Cin  (carry_q),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  assign last_bit = (cnt_q == LastCnt);

`ifdef BIT_SERIAL_SUB_EN
  logic sub_q;
  // In subtract mode the final carry is inverted to report a borrow.
  assign final_cout = fa_cout ^ sub_q;
`else
  assign final_cout = fa_cout;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef BIT_SERIAL_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q <= a;
            cnt_q  <= '0;
`ifdef BIT_SERIAL_SUB_EN
            // a - b - cin == a + ~b + ~cin (mod 2^WIDTH)
            b_sr_q  <= sub_mode ? ~b : b;
            carry_q <= cin ^ sub_mode;
            sub_q   <= sub_mode;
`else
            b_sr_q  <= b;
            carry_q <= cin;
`endif
          end
        end
        SHIFT: begin
          carry_q <= fa_cout;
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          s_sr_q  <= {fa_sum, s_sr_q[WIDTH-1:1]};
          cnt_q   <= cnt_q + CntW'(1);
          if (last_bit) begin
            sum_q  <= {fa_sum, s_sr_q[WIDTH-1:1]};
            cout_q <= final_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder; exercises subtract mode when BIT_SERIAL_SUB_EN is set.
module tb_bit_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin, sub_mode;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef BIT_SERIAL_SUB_EN
    .sub_mode (sub_mode),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout)
  );

  // Reference: integer add or subtract; top bit is carry (add) or borrow (sub).
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic sm);
    longint d;
    logic [W:0] r;
    if (sm) begin
      d = longint'(x) - longint'(y) - longint'(ci);
      r = {(d < 0), W'(d)};
    end else begin
      d = longint'(x) + longint'(y) + longint'(ci);
      r = (W+1)'(d);
    end
    return r;
  endfunction

  function automatic logic rand_sub();
`ifdef BIT_SERIAL_SUB_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  // Returns at the falling edge right after the accepting clock edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic ts);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub_mode = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < int'(W) + 4) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_mode = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, cout} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got busy/done/cout %b want 000", {busy, done, cout});
    end
    checks++;
    if (sum !== '0) begin
      errors++; $display("FAIL reset_sum: got %h want 00", sum);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va[3], vb[3];
    logic         vc[3];
    logic [W:0]   exp;
    va[0] = 8'h5A; vb[0] = 8'h3C; vc[0] = 1'b0;
    va[1] = 8'hFF; vb[1] = 8'h01; vc[1] = 1'b0;
    va[2] = 8'hFF; vb[2] = 8'hFF; vc[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = model(va[i], vb[i], vc[i], 1'b0);
      start_op(va[i], vb[i], vc[i], 1'b0);
      for (int j = 0; j < int'(W); j++) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL dir%0d_busy_c%0d: got busy=%b done=%b want busy=1 done=0", i, j, busy, done);
        end
        @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL dir%0d_done: got done=%b busy=%b want 1 0", i, done, busy);
      end
      checks++;
      if ({cout, sum} !== exp) begin
        errors++; $display("FAIL dir%0d_result: got %b_%h want %b_%h", i, cout, sum, exp[W], exp[W-1:0]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL dir%0d_pulse: got done=%b want 0", i, done);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [W-1:0] ta, tbv;
    logic [W:0]   exp;
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout} !== 3'b000 || sum !== '0) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b done=%b cout=%b sum=%h want 0 0 0 00", busy, done, cout, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    ta = W'($urandom); tbv = W'($urandom);
    exp = model(ta, tbv, 1'b1, 1'b0);
    start_op(ta, tbv, 1'b1, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc != int'(W) || {cout, sum} !== exp) begin
      errors++;
      $display("FAIL rst_after: got lat=%0d %b_%h want lat=%0d %b_%h", cyc, cout, sum, W, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    logic [W-1:0] a1, b1, a3, b3;
    logic [W:0]   exp1, exp3;
    a1 = 8'h37; b1 = 8'h81; a3 = 8'hC4; b3 = 8'h2B;
    exp1 = model(a1, b1, 1'b0, 1'b0);
    exp3 = model(a3, b3, 1'b1, 1'b0);
    start_op(a1, b1, 1'b0, 1'b0);
    a = ~a1; b = b1 ^ 8'h5A; cin = 1'b1;
    for (int j = 0; j < int'(W); j++) begin
      start = (j == 1 || j == 4);
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || {cout, sum} !== exp1) begin
      errors++;
      $display("FAIL ign_result: got done=%b %b_%h want 1 %b_%h", done, cout, sum, exp1[W], exp1[W-1:0]);
    end
    a = a3; b = b3; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ign_done_start: got busy=%b done=%b want 0 0", busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc != int'(W) || {cout, sum} !== exp3) begin
      errors++;
      $display("FAIL ign_next: got lat=%0d %b_%h want lat=%0d %b_%h", cyc, cout, sum, W, exp3[W], exp3[W-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, gap;
    logic [W:0] exp1, exp2;
    exp1 = model(8'h21, 8'h43, 1'b0, 1'b0);
    exp2 = model(8'hE0, 8'h40, 1'b1, 1'b0);
    start_op(8'h21, 8'h43, 1'b0, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc != int'(W) || {cout, sum} !== exp1) begin
      errors++; $display("FAIL b2b_first: got lat=%0d %b_%h want lat=%0d %b_%h",
                         cyc, cout, sum, W, exp1[W], exp1[W-1:0]);
    end
    @(negedge clk);
    a = 8'hE0; b = 8'h40; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gap = 2;
    while (done !== 1'b1 && gap < int'(W) + 6) begin
      checks++;
      if ({cout, sum} !== exp1) begin
        errors++; $display("FAIL b2b_hold_g%0d: got %b_%h want %b_%h", gap, cout, sum, exp1[W], exp1[W-1:0]);
      end
      @(negedge clk);
      gap++;
    end
    // DONE->IDLE edge, accepting edge, then WIDTH SHIFT edges.
    checks++;
    if (gap != int'(W) + 2) begin
      errors++; $display("FAIL b2b_gap: got %0d want %0d", gap, W + 2);
    end
    checks++;
    if ({cout, sum} !== exp2) begin
      errors++; $display("FAIL b2b_second: got %b_%h want %b_%h", cout, sum, exp2[W], exp2[W-1:0]);
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [W-1:0] ta, tbv;
    logic         tc, ts;
    logic [W:0]   exp;
    for (int i = 0; i < 24; i++) begin
      ta = W'($urandom); tbv = W'($urandom); tc = 1'($urandom); ts = rand_sub();
      exp = model(ta, tbv, tc, ts);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(ta, tbv, tc, ts);
      wait_done(cyc);
      checks++;
      if (cyc != int'(W) || {cout, sum} !== exp) begin
        errors++;
        $display("FAIL rand%0d: a=%h b=%h cin=%b sub=%b got lat=%0d %b_%h want lat=%0d %b_%h",
                 i, ta, tbv, tc, ts, cyc, cout, sum, W, exp[W], exp[W-1:0]);
      end
    end
  endtask

`ifdef BIT_SERIAL_SUB_EN
  task automatic test_sub();
    int cyc;
    start_op(8'h10, 8'h01, 1'b0, 1'b1);
    wait_done(cyc);
    checks++;
    if ({cout, sum} !== 9'h00F) begin
      errors++; $display("FAIL sub_10_01: got %b_%h want 0_0f", cout, sum);
    end
    start_op(8'h10, 8'h20, 1'b0, 1'b1);
    wait_done(cyc);
    checks++;
    if ({cout, sum} !== 9'h1F0) begin
      errors++; $display("FAIL sub_10_20: got %b_%h want 1_f0", cout, sum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
`ifdef BIT_SERIAL_SUB_EN
    test_sub();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
